// File: rtl/timing_pkg.sv
// timing_pkg: state encoding and timing constants shared by the pulse generator and the timing-measurement block
package timing_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DELAY  = 3'd1,
        ACTIVE = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_t;
    localparam int MIN_GAP = 1;
endpackage

// File: rtl/phase_counter.sv
// phase_counter: loadable down-counter, shared by the DELAY, ACTIVE and GAP phases
module phase_counter #(
    parameter int _RAM_WIDTH = 32
) (
    input  logic                  io_clk,
    input  logic                  io_rstn,
    input  logic                  load,
    input  logic [_RAM_WIDTH-1:0] load_val,
    input  logic                  dec,
    output logic                  zero
);
    logic [_RAM_WIDTH-1:0] cnt;
    always_ff @(posedge io_clk)
        if (!io_rstn) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && cnt != '0) cnt <= cnt - 1'b1;
    assign zero = cnt == '0;
endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: programmable pulse-train generator with delay, width, period, count and feedback abort
module pulse_gen
    import timing_pkg::*;
#(
    parameter int _RAM_WIDTH = 32
) (
    input  logic                  io_clk,
    input  logic                  io_rstn,
    input  logic                  io_start,
    input  logic                  io_stop,
    input  logic                  io_defaultLevel_Pulse,
    input  logic [_RAM_WIDTH-1:0] io_delay,
    input  logic [_RAM_WIDTH-1:0] io_width,
    input  logic [_RAM_WIDTH-1:0] io_period,
    input  logic [_RAM_WIDTH-1:0] io_count,
    input  logic                  io_fbEn,
    input  logic                  io_fbCatch,
    output logic                  io_pulsePort,
    output logic                  io_busy,
    output logic                  io_done,
    output logic [_RAM_WIDTH-1:0] io_pulseCnt
);
    localparam logic [_RAM_WIDTH-1:0] ONE = {{(_RAM_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [_RAM_WIDTH-1:0] MIN_G = _RAM_WIDTH'(MIN_GAP);
    state_t state, nxt;
    logic lvl, lvl_n, fb_en, go, abort, last, zero, load, dec;
    logic [_RAM_WIDTH-1:0] w_len, g_len, cnt_lim, w_in, g_in, load_val;

    assign w_in  = io_width == '0 ? ONE : io_width;
    assign g_in  = io_period > w_in ? io_period - w_in : MIN_G;
    assign go    = state == IDLE && io_start && !io_stop;
    assign abort = (io_stop && (state == DELAY || state == ACTIVE || state == GAP)) ||
                   (fb_en && io_fbCatch && (state == ACTIVE || state == GAP));
    assign last  = cnt_lim != '0 && io_pulseCnt == cnt_lim;
    assign lvl_n = state == IDLE ? io_defaultLevel_Pulse : lvl;
    assign io_busy = state != IDLE;
    assign io_done = state == DONE;

    phase_counter #(._RAM_WIDTH(_RAM_WIDTH)) u_phase (
        .io_clk(io_clk), .io_rstn(io_rstn), .load(load), .load_val(load_val), .dec(dec), .zero(zero)
    );

    // Each phase loads its length minus one; the zero flag marks the phase's final cycle
    always_comb begin
        nxt = state;
        load = 1'b0;
        load_val = '0;
        dec = 1'b0;
        case (state)
            IDLE: if (go) begin
                nxt = io_delay != '0 ? DELAY : ACTIVE;
                load = 1'b1;
                load_val = io_delay != '0 ? io_delay - ONE : w_in - ONE;
            end
            DELAY, ACTIVE, GAP: if (abort) nxt = DONE;
                else if (!zero) dec = 1'b1;
                else begin
                    nxt = state != ACTIVE ? ACTIVE : (last ? DONE : GAP);
                    load = 1'b1;
                    load_val = nxt == GAP ? g_len - ONE : w_len - ONE;
                end
            default: nxt = IDLE;
        endcase
    end

    // Output is driven from the next state so it changes on the same edge as the state
    always_ff @(posedge io_clk)
        if (!io_rstn) begin
            state <= IDLE;
            io_pulsePort <= io_defaultLevel_Pulse;
            io_pulseCnt <= '0;
            lvl <= 1'b0;
            fb_en <= 1'b0;
            w_len <= ONE;
            g_len <= ONE;
            cnt_lim <= '0;
        end else begin
            state <= nxt;
            io_pulsePort <= nxt == ACTIVE ? ~lvl_n : (nxt == IDLE ? io_defaultLevel_Pulse : lvl_n);
            if (go) begin
                lvl <= io_defaultLevel_Pulse;
                fb_en <= io_fbEn;
                w_len <= w_in;
                g_len <= g_in;
                cnt_lim <= io_count;
            end
            if (go) io_pulseCnt <= io_delay == '0 ? ONE : '0;
            else if (nxt == ACTIVE && state != ACTIVE && !(&io_pulseCnt)) io_pulseCnt <= io_pulseCnt + ONE;
        end
endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: randomized pulse trains checked cycle by cycle against a waveform-level reference model
module tb_pulse_gen;
    logic io_clk = 1'b0, io_rstn = 1'b0, io_start = 1'b0, io_stop = 1'b0;
    logic io_defaultLevel_Pulse = 1'b0, io_fbEn = 1'b0, io_fbCatch = 1'b0;
    logic [31:0] io_delay = '0, io_width = '0, io_period = '0, io_count = '0;
    logic io_pulsePort, io_busy, io_done;
    logic [31:0] io_pulseCnt;

    typedef struct packed {
        logic port;
        logic busy;
        logic done;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0, n_bad = 0;
    logic [31:0] cnt_hold = '0;

    pulse_gen #(._RAM_WIDTH(32)) dut (
        .io_clk(io_clk), .io_rstn(io_rstn), .io_start(io_start), .io_stop(io_stop),
        .io_defaultLevel_Pulse(io_defaultLevel_Pulse), .io_delay(io_delay), .io_width(io_width),
        .io_period(io_period), .io_count(io_count), .io_fbEn(io_fbEn), .io_fbCatch(io_fbCatch),
        .io_pulsePort(io_pulsePort), .io_busy(io_busy), .io_done(io_done), .io_pulseCnt(io_pulseCnt)
    );

    always #5 io_clk = ~io_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, req);
        end
    endtask

    // Monitor: one expected output record per clock cycle
    always @(negedge io_clk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("pulsePort", 32'(io_pulsePort), 32'(x.port));
            chk("busy", 32'(io_busy), 32'(x.busy));
            chk("done", 32'(io_done), 32'(x.done));
            chk("pulseCnt", io_pulseCnt, x.cnt);
        end
    end

    task automatic step(input logic rn, input logic st, input logic sp, input logic lv, input logic fe,
                        input logic fc, input logic [31:0] d, input logic [31:0] w, input logic [31:0] p,
                        input logic [31:0] c, input exp_t e);
        io_rstn = rn; io_start = st; io_stop = sp; io_defaultLevel_Pulse = lv;
        io_fbEn = fe; io_fbCatch = fc;
        io_delay = d; io_width = w; io_period = p; io_count = c;
        @(posedge io_clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int nc, input logic rn);
        logic l;
        for (int i = 0; i < nc; i++) begin
            l = 1'($urandom % 2);
            if (!rn) cnt_hold = '0;
            step(rn, 1'b0, 1'($urandom % 2), l, 1'($urandom % 2), 1'($urandom % 2),
                 $urandom, $urandom, $urandom, $urandom, '{l, 1'b0, 1'b0, cnt_hold});
        end
    endtask

    // Expected waveform built from delay/pulse/gap segment lengths, then cut at the first abort
    task automatic train(input logic lv, input int d, input int w, input int per, input int c, input int sa,
                         input logic fe, input int fa, input int ra, input int tail);
        int wm, g, n, e, lst;
        logic rv, l, st;
        logic pq[$];
        int cq[$];
        exp_t x;
        wm = w == 0 ? 1 : w;
        g = per > wm ? per - wm : 1;
        for (int i = 0; i < d; i++) begin pq.push_back(lv); cq.push_back(0); end
        for (int p = 1; c == 0 ? pq.size() < 400 : p <= c; p++) begin
            for (int i = 0; i < wm; i++) begin pq.push_back(~lv); cq.push_back(p); end
            if (p != c) for (int i = 0; i < g; i++) begin pq.push_back(lv); cq.push_back(p); end
        end
        n = pq.size();
        e = n;
        if (sa >= 1 && sa < e) e = sa;
        if (fe && fa > d && fa < e) e = fa;
        if (sa == 0) e = -1;
        rv = ra >= 1 && ra <= e;
        lst = (rv ? ra : (e < 0 ? 0 : e)) + tail;
        for (int t = 0; t <= lst; t++) begin
            l = t == 0 ? lv : 1'($urandom % 2);
            st = t == 0 ? 1'b1 : ((t <= e && !(rv && t >= ra)) ? 1'($urandom % 2) : 1'b0);
            if (rv && t >= ra) x = '{l, 1'b0, 1'b0, 32'd0};
            else if (e < 0) x = '{l, 1'b0, 1'b0, cnt_hold};
            else if (t < e) x = '{pq[t], 1'b1, 1'b0, 32'(cq[t])};
            else if (t == e) x = '{lv, 1'b1, 1'b1, 32'(cq[e-1])};
            else x = '{l, 1'b0, 1'b0, 32'(cq[e-1])};
            if (t == 0)
                step(1'b1, st, sa == 0, l, fe, fe && fa == 0, 32'(d), 32'(w), 32'(per), 32'(c), x);
            else
                step(!(rv && t == ra), st, t == sa, l, fe, fe ? t == fa : 1'($urandom % 2),
                     $urandom, $urandom, $urandom, $urandom, x);
        end
        cnt_hold = rv ? 32'd0 : (e < 0 ? cnt_hold : 32'(cq[e-1]));
    endtask

    initial begin
        int c, sa, fa, ra;
        idle(3, 1'b0);
        idle(2, 1'b1);
        train(1'b0, 0, 3, 5, 2, -1, 1'b0, -1, -1, 3);
        train(1'b1, 4, 1, 1, 3, -1, 1'b0, -1, -1, 3);
        train(1'b0, 0, 2, 4, 0, 9, 1'b0, -1, -1, 3);
        train(1'b0, 0, 2, 3, 5, -1, 1'b1, 1, -1, 3);
        train(1'b0, 0, 2, 3, 5, -1, 1'b0, 1, -1, 3);
        train(1'b0, 0, 2, 3, 1, 0, 1'b0, -1, -1, 3);
        train(1'b1, 0, 4, 6, 2, -1, 1'b0, -1, 2, 3);
        train(1'b1, 2, 0, 0, 3, -1, 1'b1, 2, -1, 2);
        for (int k = 0; k < 40; k++) begin
            c = int'($urandom_range(0, 4));
            sa = c == 0 ? int'($urandom_range(1, 40)) : ($urandom % 3 == 0 ? int'($urandom_range(0, 25)) : -1);
            fa = int'($urandom_range(1, 25));
            ra = $urandom % 8 == 0 ? int'($urandom_range(1, 10)) : -1;
            train(1'($urandom % 2), int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 8)), c, sa, 1'($urandom % 2), fa, ra, int'($urandom_range(1, 3)));
        end
        idle(3, 1'b1);
        @(negedge io_clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
